// File: rtl/ten_bit_register_bank_reader.sv
// ten_bit_register_bank_reader
//   Register bank of DEPTH entries, each WIDTH bits wide. Writes go in through a
//   plain write-enable port. Reads leave through a valid/ready handshake, so the
//   consumer (control unit / ALU operand latches) can stall the read side.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   d             write data
//   w             write enable; d -> entry[w_addr] at posedge clk
//   w_addr        write address
//   rd_req        read request; accepted when rd_req_ready=1
//   rd_addr       read address, sampled when the read is accepted
//   rd_req_ready  bank can accept a read this cycle
//   rd_valid      rd_data holds a completed read
//   rd_data       read result; held while rd_valid=1 and rd_ready=0
//   rd_ready      consumer takes rd_data this cycle
//
// Configuration
//   READ_BYPASS_EN  when defined, a read accepted on the same edge as a write to
//                   the same address returns the new data (write-first). When it
//                   is undefined (the default), that read returns the old entry
//                   value (read-first).

module ten_bit_register_bank_reader #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d,
    input  logic              w,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req_ready,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              rd_ready
);

    typedef enum logic {IDLE, VALID} state_t;

    state_t                       state;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [WIDTH-1:0]             read_val;
    logic                         accept;

    // Storage: the write side does not depend on the read FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (w) begin
            mem[w_addr] <= d;
        end
    end

    // Data sampled by an accepted read. The default build is read-first: an
    // accepted read sees the entry value from before the same-edge write.
`ifdef READ_BYPASS_EN
    assign read_val = (w && (w_addr == rd_addr)) ? d : mem[rd_addr];
`else
    assign read_val = mem[rd_addr];
`endif

    // A slot opens when nothing is held, or when the held result leaves this
    // cycle. This gives one read per cycle while the consumer keeps rd_ready high.
    assign rd_req_ready = (state == IDLE) || rd_ready;
    assign accept       = rd_req && rd_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= VALID;
                        rd_valid <= 1'b1;
                        rd_data  <= read_val;
                    end
                end
                VALID: begin
                    if (rd_ready) begin
                        if (accept) begin
                            rd_data <= read_val;
                        end else begin
                            // rd_data keeps its last value after the handoff.
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                        end
                    end
                    // When rd_ready=0, rd_data stays frozen, even if its source
                    // entry is rewritten.
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ten_bit_register_bank_reader.sv
// Testbench for ten_bit_register_bank_reader. It keeps an abstract model of the
// bank (an array plus one held result) and checks the DUT against it on every
// falling edge. Directed literal checks pin the model to hand-computed values.

module tb_ten_bit_register_bank_reader;

    localparam int WIDTH  = 10;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  d = '0;
    logic              w = 1'b0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_req_ready;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    ten_bit_register_bank_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .d            (d),
        .w            (w),
        .w_addr       (w_addr),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_req_ready (rd_req_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready)
    );

    always #5 clk = ~clk;

    // Model. A result is "held" until the consumer takes it. A new read gets in
    // when nothing is held or when the held result is taken on the same edge.
    int unsigned m_mem [DEPTH];
    bit          m_valid;
    int unsigned m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_valid = 0;
            m_data  = 0;
        end else begin
            bit take_new;
            take_new = rd_req && (!m_valid || rd_ready);
            if (take_new) begin
`ifdef READ_BYPASS_EN
                m_data = (w && w_addr == rd_addr) ? int'(d) : m_mem[rd_addr];
`else
                m_data = m_mem[rd_addr];
`endif
                m_valid = 1;
            end else if (rd_ready) begin
                m_valid = 0;
            end
            if (w) m_mem[w_addr] = d;
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        checks++;
        if (rd_valid !== m_valid) begin
            errors++;
            $display("FAIL model_valid t=%0t dut=%0d model=%0d", $time, rd_valid, m_valid);
        end
        checks++;
        if (rd_data !== WIDTH'(m_data)) begin
            errors++;
            $display("FAIL model_data t=%0t dut=%0d model=%0d", $time, rd_data, m_data);
        end
        checks++;
        if (rd_req_ready !== (!m_valid || rd_ready)) begin
            errors++;
            $display("FAIL model_req_ready t=%0t dut=%0d model=%0d", $time, rd_req_ready,
                     (!m_valid || rd_ready));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Wait for the next rising edge, then move 2 time units past it. Inputs are
    // changed there, so they are stable around both clock edges.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_valid", 32'(rd_valid), 0);
        chk("reset_data", 32'(rd_data), 0);
        chk("reset_req_ready", 32'(rd_req_ready), 1);
        cyc();
        rst = 1'b0;

        // 1: read addr 5 after reset -> 0, valid for one cycle
        rd_req = 1; rd_addr = 5; rd_ready = 1;
        cyc(); rd_req = 0; #1;
        chk("t1_valid", 32'(rd_valid), 1);
        chk("t1_data", 32'(rd_data), 0);
        cyc(); #1;
        chk("t1_valid_drop", 32'(rd_valid), 0);

        // 2: write 45 -> addr 2, read it back
        w = 1; d = 45; w_addr = 2;
        cyc(); w = 0;
        rd_req = 1; rd_addr = 2;
        cyc(); rd_req = 0; #1;
        chk("t2_data", 32'(rd_data), 45);
        chk("t2_valid", 32'(rd_valid), 1);
        cyc(); #1;
        chk("t2_valid_drop", 32'(rd_valid), 0);

        // 3: w=0 leaves the entry unchanged
        d = 100; w = 0; w_addr = 2;
        cyc();
        rd_req = 1; rd_addr = 2;
        cyc(); rd_req = 0; #1;
        chk("t3_data", 32'(rd_data), 45);
        cyc();

        // 4: stall; rd_data stays frozen while entry 2 is rewritten
        rd_ready = 0; rd_req = 1; rd_addr = 2;
        cyc(); rd_req = 0; w = 1; d = 101; w_addr = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_data", 32'(rd_data), 45);
            chk("t4_stall_valid", 32'(rd_valid), 1);
            chk("t4_stall_req_ready", 32'(rd_req_ready), 0);
            cyc();
        end
        w = 0; rd_ready = 1; #1;
        chk("t4_req_ready_follows", 32'(rd_req_ready), 1);
        cyc(); #1;
        chk("t4_done_valid", 32'(rd_valid), 0);
        chk("t4_done_data_kept", 32'(rd_data), 45);
        rd_req = 1; rd_addr = 2;
        cyc(); rd_req = 0; #1;
        chk("t4_new_data", 32'(rd_data), 101);
        cyc();

        // 5: read and write addr 3 on the same edge
        w = 1; d = 105; w_addr = 3; rd_req = 1; rd_addr = 3;
        cyc(); w = 0; rd_req = 0; #1;
`ifdef READ_BYPASS_EN
        chk("t5_same_edge", 32'(rd_data), 105);
`else
        chk("t5_same_edge", 32'(rd_data), 0);
`endif
        cyc();
        rd_req = 1; rd_addr = 3;
        cyc(); rd_req = 0; #1;
        chk("t5_later_read", 32'(rd_data), 105);
        cyc();

        // 6: back-to-back reads, then asynchronous reset while VALID
        rd_req = 1; rd_addr = 2;
        cyc(); rd_addr = 3; #1;
        chk("t6_b2b_first", 32'(rd_data), 101);
        chk("t6_b2b_valid1", 32'(rd_valid), 1);
        cyc(); rd_req = 0; #1;
        chk("t6_b2b_second", 32'(rd_data), 105);
        chk("t6_b2b_valid2", 32'(rd_valid), 1);
        rst = 1; #1;
        chk("t6_async_valid", 32'(rd_valid), 0);
        chk("t6_async_data", 32'(rd_data), 0);
        cyc(); rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1; rd_addr = ADDR_W'(i);
            cyc(); #1;
            chk("t6_post_reset_data", 32'(rd_data), 0);
            chk("t6_post_reset_valid", 32'(rd_valid), 1);
        end
        rd_req = 0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
